// File: rtl/hdmi_img_pkg.sv
// rtl/hdmi_img_pkg.sv - shared image constants and arbiter state type
// MEM_ADDR_W grows by one bank bit when HDMI_IMG_DOUBLE_BUFFER_EN is defined.
package hdmi_img_pkg;
  localparam int IMG_W      = 224;
  localparam int IMG_H      = 224;
  localparam int IMG_ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int PIXEL_W    = 24;
`ifdef HDMI_IMG_DOUBLE_BUFFER_EN
  localparam int MEM_ADDR_W = IMG_ADDR_W + 1;
`else
  localparam int MEM_ADDR_W = IMG_ADDR_W;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Clear takes precedence over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/hdmi_img_mem_arbiter.sv
// rtl/hdmi_img_mem_arbiter.sv - image BRAM arbiter: compositor reads win, host loads fill idle slots
// Optional front/back bank swapping on frame_start when HDMI_IMG_DOUBLE_BUFFER_EN is defined.
module hdmi_img_mem_arbiter
  import hdmi_img_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   pixel_clk,
  input  logic                   rst,
  input  logic                   vid_req,
  input  logic [IMG_ADDR_W-1:0]  vid_addr,
  output logic [PIXEL_W-1:0]     vid_rdata,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [IMG_ADDR_W-1:0]  host_addr,
  input  logic [PIXEL_W-1:0]     host_wdata,
  output logic                   host_gnt,
  output logic                   host_rvalid,
  output logic [PIXEL_W-1:0]     host_rdata,
  input  logic                   frame_start,
  input  logic                   swap_req,
  output logic                   swap_done,
  input  logic                   stall_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [PIXEL_W-1:0]     mem_wdata,
  input  logic [PIXEL_W-1:0]     mem_rdata
);
  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [PIXEL_W-1:0]      r_rdata;
  logic [MEM_ADDR_W-1:0]   w_vid_addr;
  logic [MEM_ADDR_W-1:0]   w_host_addr;
  logic                    w_gnt;

`ifdef HDMI_IMG_DOUBLE_BUFFER_EN
  logic r_front_bank;
  logic r_swap_pending;
  logic w_swap_fire;

  // A swap_req arriving on the frame_start cycle itself still takes effect now.
  assign w_swap_fire = frame_start && (r_swap_pending || swap_req);

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_front_bank   <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_swap_fire) begin
      r_front_bank   <= ~r_front_bank;
      r_swap_pending <= 1'b0;
    end else if (swap_req) begin
      r_swap_pending <= 1'b1;
    end
  end

  assign swap_done   = w_swap_fire && !rst;
  assign w_vid_addr  = {r_front_bank, vid_addr};
  assign w_host_addr = {~r_front_bank, host_addr};
`else
  logic w_unused_swap;
  assign w_unused_swap = frame_start ^ swap_req;
  assign swap_done     = 1'b0;
  assign w_vid_addr    = vid_addr;
  assign w_host_addr   = host_addr;
`endif

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Combinational mux keeps the compositor's address-to-data latency at one cycle.
  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    w_gnt       = 1'b0;
    host_rvalid = 1'b0;
    w_state_nxt = r_state;
    if (!rst) begin
      if (vid_req) begin
        mem_en   = 1'b1;
        mem_addr = w_vid_addr;
      end else if ((r_state == IDLE) && host_req) begin
        w_gnt     = 1'b1;
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = w_host_addr;
        mem_wdata = host_wdata;
      end
      case (r_state)
        IDLE:    if (w_gnt && !host_we) w_state_nxt = RD_WAIT;
        RD_WAIT: w_state_nxt = RD_RESP;
        RD_RESP: begin
          host_rvalid = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (r_state == RD_WAIT) begin
      r_rdata <= mem_rdata;
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .i_clk   (pixel_clk),
    .i_rst   (rst),
    .i_inc   (host_req && vid_req),
    .i_clr   (stall_clr),
    .o_count (stall_cnt)
  );

  assign host_gnt   = w_gnt;
  assign host_rdata = r_rdata;
  assign vid_rdata  = mem_rdata;
endmodule

// File: tb/tb_hdmi_img_mem_arbiter.sv
// tb/tb_hdmi_img_mem_arbiter.sv - directed self-checking bench for hdmi_img_mem_arbiter
// Swap scenarios run only when HDMI_IMG_DOUBLE_BUFFER_EN is defined.
module tb_hdmi_img_mem_arbiter;
`ifdef HDMI_IMG_DOUBLE_BUFFER_EN
  localparam int MAW = 17;
`else
  localparam int MAW = 16;
`endif

  logic             pixel_clk;
  logic             rst;
  logic             vid_req;
  logic [15:0]      vid_addr;
  logic [23:0]      vid_rdata;
  logic             host_req;
  logic             host_we;
  logic [15:0]      host_addr;
  logic [23:0]      host_wdata;
  logic             host_gnt;
  logic             host_rvalid;
  logic [23:0]      host_rdata;
  logic             frame_start;
  logic             swap_req;
  logic             swap_done;
  logic             stall_clr;
  logic [15:0]      stall_cnt;
  logic             mem_en;
  logic             mem_we;
  logic [MAW-1:0]   mem_addr;
  logic [23:0]      mem_wdata;
  logic [23:0]      mem_rdata;

  logic [23:0]      bram [0:(1<<MAW)-1];
  logic             tb_host_msb;
  logic             tb_vid_msb;
  int               n_pass;
  int               n_total;

  hdmi_img_mem_arbiter dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_rdata   (vid_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .frame_start (frame_start),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .stall_clr   (stall_clr),
    .stall_cnt   (stall_cnt),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  function automatic logic [MAW-1:0] host_exp(input logic [15:0] a);
`ifdef HDMI_IMG_DOUBLE_BUFFER_EN
    return {tb_host_msb, a};
`else
    return a;
`endif
  endfunction

  function automatic logic [MAW-1:0] vid_exp(input logic [15:0] a);
`ifdef HDMI_IMG_DOUBLE_BUFFER_EN
    return {tb_vid_msb, a};
`else
    return a;
`endif
  endfunction

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vid_req = 1'b1; host_req = 1'b1; host_we = 1'b1;
    host_addr = 16'h0001; host_wdata = 24'hABCDEF;
    #2;
    n_total++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en got %b exp 0", mem_en); else n_pass++;
    n_total++; if (mem_addr !== '0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 24'h0) $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); else n_pass++;
    n_total++; if (host_gnt !== 1'b0) $display("FAIL reset_host_gnt got %b exp 0", host_gnt); else n_pass++;
    n_total++; if ({host_rvalid, host_rdata, swap_done, stall_cnt} !== 42'h0)
      $display("FAIL reset_regs got %h exp 0", {host_rvalid, host_rdata, swap_done, stall_cnt}); else n_pass++;
    tick(); tick();
    rst = 1'b0; vid_req = 1'b0; host_req = 1'b0;
    tick();
  endtask

  task automatic test_host_write_read();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 24'hFF8040;
    #1;
    n_total++; if (host_gnt !== 1'b1) $display("FAIL wr_gnt got %b exp 1", host_gnt); else n_pass++;
    n_total++; if ({mem_en, mem_we} !== 2'b11) $display("FAIL wr_en_we got %b exp 11", {mem_en, mem_we}); else n_pass++;
    n_total++; if (mem_addr !== host_exp(16'h0010)) $display("FAIL wr_addr got %h exp %h", mem_addr, host_exp(16'h0010)); else n_pass++;
    n_total++; if (mem_wdata !== 24'hFF8040) $display("FAIL wr_wdata got %h exp ff8040", mem_wdata); else n_pass++;
    tick();
    host_addr = 16'h0011; host_wdata = 24'h000001;
    #1;
    n_total++; if (host_gnt !== 1'b1) $display("FAIL b2b_wr_gnt got %b exp 1", host_gnt); else n_pass++;
    tick();
    host_we = 1'b0; host_addr = 16'h0010;
    #1;
    n_total++; if ({host_gnt, mem_we} !== 2'b10) $display("FAIL rd_gnt got %b exp 10", {host_gnt, mem_we}); else n_pass++;
    tick();
    host_req = 1'b0;
    #1;
    n_total++; if (host_rvalid !== 1'b0) $display("FAIL rd_rvalid_t1 got %b exp 0", host_rvalid); else n_pass++;
    tick();
    n_total++; if (host_rvalid !== 1'b1) $display("FAIL rd_rvalid_t2 got %b exp 1", host_rvalid); else n_pass++;
    n_total++; if (host_rdata !== 24'hFF8040) $display("FAIL rd_rdata got %h exp ff8040", host_rdata); else n_pass++;
    tick();
    n_total++; if (host_rvalid !== 1'b0) $display("FAIL rd_rvalid_t3 got %b exp 0", host_rvalid); else n_pass++;
  endtask

  task automatic test_video_latency();
    vid_req = 1'b1; vid_addr = 16'h0100;
    #1;
    n_total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, vid_exp(16'h0100)})
      $display("FAIL vid_issue got %h exp %h", {mem_en, mem_we, mem_addr}, {2'b10, vid_exp(16'h0100)}); else n_pass++;
    tick();
    vid_req = 1'b0;
    #1;
    n_total++; if (vid_rdata !== 24'h123456) $display("FAIL vid_rdata got %h exp 123456", vid_rdata); else n_pass++;
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    #1;
    n_total++; if (host_gnt !== 1'b1) $display("FAIL mix_host_gnt got %b exp 1", host_gnt); else n_pass++;
    tick();
    host_req = 1'b0; vid_req = 1'b1; vid_addr = 16'h0100;
    #1;
    n_total++; if (mem_addr !== vid_exp(16'h0100)) $display("FAIL mix_vid_addr got %h exp %h", mem_addr, vid_exp(16'h0100)); else n_pass++;
    n_total++; if (vid_rdata !== 24'hFF8040) $display("FAIL mix_host_data got %h exp ff8040", vid_rdata); else n_pass++;
    tick();
    vid_req = 1'b0;
    #1;
    n_total++; if (vid_rdata !== 24'h123456) $display("FAIL mix_vid_rdata got %h exp 123456", vid_rdata); else n_pass++;
    n_total++; if ({host_rvalid, host_rdata} !== {1'b1, 24'hFF8040})
      $display("FAIL mix_host_resp got %h exp 1ff8040", {host_rvalid, host_rdata}); else n_pass++;
    tick();
  endtask

  task automatic test_collision();
    int gnt_seen;
    gnt_seen = 0;
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 24'h0A0B0C;
    vid_req = 1'b1; vid_addr = 16'h0005;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (host_gnt !== 1'b0) gnt_seen++;
      tick();
    end
    n_total++; if (gnt_seen !== 0) $display("FAIL coll_no_gnt got %0d grants exp 0", gnt_seen); else n_pass++;
    vid_req = 1'b0;
    #1;
    n_total++; if (host_gnt !== 1'b1) $display("FAIL coll_late_gnt got %b exp 1", host_gnt); else n_pass++;
    n_total++; if (stall_cnt !== 16'd5) $display("FAIL coll_stall_cnt got %0d exp 5", stall_cnt); else n_pass++;
    tick();
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    host_req = 1'b1; host_we = 1'b0; vid_req = 1'b1; vid_addr = 16'h0000;
    repeat (70000) @(posedge pixel_clk);
    #1;
    n_total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_cnt got %h exp ffff", stall_cnt); else n_pass++;
    stall_clr = 1'b1;
    tick();
    n_total++; if (stall_cnt !== 16'h0000) $display("FAIL sat_clr_wins got %h exp 0", stall_cnt); else n_pass++;
    stall_clr = 1'b0; host_req = 1'b0; vid_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    host_req = 1'b1; vid_req = 1'b1;
    tick();
    vid_req = 1'b0; host_we = 1'b0; host_addr = 16'h0010;
    #1;
    n_total++; if ({host_gnt, stall_cnt} !== {1'b1, 16'd1}) $display("FAIL rmr_pre got %h exp 10001", {host_gnt, stall_cnt}); else n_pass++;
    tick();
    host_req = 1'b0; rst = 1'b1;
    #1;
    n_total++; if ({mem_en, host_rvalid, host_rdata, stall_cnt} !== 42'h0)
      $display("FAIL rmr_in_reset got %h exp 0", {mem_en, host_rvalid, host_rdata, stall_cnt}); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_total++; if (host_rvalid !== 1'b0) $display("FAIL rmr_rvalid_a got %b exp 0", host_rvalid); else n_pass++;
    tick();
    n_total++; if (host_rvalid !== 1'b0) $display("FAIL rmr_rvalid_b got %b exp 0", host_rvalid); else n_pass++;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0030;
    #1;
    n_total++; if (host_gnt !== 1'b1) $display("FAIL rmr_idle_gnt got %b exp 1", host_gnt); else n_pass++;
    tick();
    host_req = 1'b0;
    tick();
  endtask

`ifdef HDMI_IMG_DOUBLE_BUFFER_EN
  task automatic test_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    repeat (8) tick();
    swap_req = 1'b1;
    #1;
    n_total++; if (swap_done !== 1'b0) $display("FAIL swap_early got %b exp 0", swap_done); else n_pass++;
    tick();
    swap_req = 1'b0; frame_start = 1'b1;
    #1;
    n_total++; if (swap_done !== 1'b1) $display("FAIL swap_done got %b exp 1", swap_done); else n_pass++;
    tick();
    frame_start = 1'b0;
    tb_host_msb = 1'b0; tb_vid_msb = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020;
    #1;
    n_total++; if ({swap_done, mem_addr} !== {1'b0, 17'h00020})
      $display("FAIL swap_host_bank got %h exp 00020", {swap_done, mem_addr}); else n_pass++;
    tick();
    host_req = 1'b0; vid_req = 1'b1; vid_addr = 16'h0040; frame_start = 1'b1;
    #1;
    n_total++; if ({swap_done, mem_addr} !== {1'b0, 17'h10040})
      $display("FAIL swap_absorbed got %h exp 10040", {swap_done, mem_addr}); else n_pass++;
    tick();
    vid_req = 1'b0; swap_req = 1'b1;
    #1;
    n_total++; if (swap_done !== 1'b1) $display("FAIL swap_coincide got %b exp 1", swap_done); else n_pass++;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    tb_host_msb = 1'b1; tb_vid_msb = 1'b0;
    host_req = 1'b1; host_addr = 16'h0020;
    #1;
    n_total++; if (mem_addr !== 17'h10020) $display("FAIL swap_back got %h exp 10020", mem_addr); else n_pass++;
    tick();
    host_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0;
    tb_host_msb = 1'b1; tb_vid_msb = 1'b0;
    for (int i = 0; i < (1 << MAW); i++) bram[i] = 24'h0;
    bram[vid_exp(16'h0100)] = 24'h123456;
    mem_rdata = 24'h0;
    vid_addr = 16'h0; frame_start = 1'b0; swap_req = 1'b0; stall_clr = 1'b0;
    test_reset();
    test_host_write_read();
    test_video_latency();
    test_collision();
    test_saturation();
    test_reset_mid_read();
`ifdef HDMI_IMG_DOUBLE_BUFFER_EN
    test_swap();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
